// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the serial-to-parallel converter
package s2p_pkg;
  localparam int S2P_DEFAULT_WIDTH = 8;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;
endpackage

// File: rtl/serial_to_parallel_inv_if.sv
// serial_to_parallel_inv_if: serial input and parallel output handshake bundle
interface serial_to_parallel_inv_if import s2p_pkg::*; #(parameter int WIDTH = S2P_DEFAULT_WIDTH);
  logic invert;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_ready;
  modport master (output invert, in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input invert, in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/serial_to_parallel_inv_mux2.sv
// serial_to_parallel_inv_mux2: 2:1 single-bit multiplexer
module serial_to_parallel_inv_mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/serial_to_parallel_inv.sv
// serial_to_parallel_inv: LSB-first serial-to-parallel converter with per-bit optional inversion
module serial_to_parallel_inv import s2p_pkg::*; #(parameter int WIDTH = S2P_DEFAULT_WIDTH) (
  input logic clk,
  input logic rst,
  serial_to_parallel_inv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_q, out_d, word;
  out_state_e state_q, state_d;
  logic bit_in, accept, last, done, xfer;
  serial_to_parallel_inv_mux2 u_inv_mux (
    .a(bus.in_data),
    .b(~bus.in_data),
    .sel(bus.invert),
    .y(bit_in)
  );
  assign last = cnt_q == CW'(WIDTH - 1);
  assign bus.in_ready = !rst && !(last && state_q == OUT_FULL && !bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign done = accept && last;
  assign xfer = state_q == OUT_FULL && bus.out_ready;
  assign word = {bit_in, shift_q};
  assign bus.out_valid = state_q == OUT_FULL;
  assign bus.out_data = out_q;
  always_comb begin
    cnt_d = accept ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    shift_d = accept ? (last ? '0 : word[WIDTH-1:1]) : shift_q;
    out_d = done ? word : out_q;
    state_d = done ? OUT_FULL : (xfer ? OUT_EMPTY : state_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      shift_q <= '0;
      out_q <= '0;
      state_q <= OUT_EMPTY;
    end else begin
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      out_q <= out_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_serial_to_parallel_inv.sv
// tb_serial_to_parallel_inv: directed self-checking bench for serial_to_parallel_inv
module tb_serial_to_parallel_inv;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  serial_to_parallel_inv_if #(.WIDTH(8)) bus ();
  serial_to_parallel_inv #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_data = ~w[i];
        repeat ($urandom_range(0, 3)) step();
      end
      bus.in_valid = 1'b1;
      bus.in_data = w[i];
      for (int n = 0; n < 20 && !bus.in_ready; n++) step();
      if (!bus.in_ready) check("in_ready_timeout", 0, 1);
      if (i == 7) check("no_early_valid", bus.out_valid, 0);
      step();
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int p0, p1, np;
    logic [7:0] d0, d1, seq;
    bit ready_ok;
    rst = 1'b1;
    bus.invert = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    send_word(8'h4D, 0);
    check("plain_valid", bus.out_valid, 1);
    check("plain_data", bus.out_data, 8'h4D);
    step();
    check("plain_pulse_one_cycle", bus.out_valid, 0);
    bus.invert = 1'b1;
    send_word(8'h4D, 0);
    check("inv_valid", bus.out_valid, 1);
    check("inv_data", bus.out_data, 8'hB2);
    step();
    bus.invert = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 1'b1;
      step();
    end
    check("bp_valid", bus.out_valid, 1);
    check("bp_data", bus.out_data, 8'hFF);
    check("bp_in_ready_low", bus.in_ready, 0);
    step();
    step();
    check("bp_hold_valid", bus.out_valid, 1);
    check("bp_hold_data", bus.out_data, 8'hFF);
    check("bp_hold_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("bp_second_valid", bus.out_valid, 1);
    check("bp_second_data", bus.out_data, 8'hFF);
    check("bp_in_ready_after", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    step();
    check("bp_drained", bus.out_valid, 0);
    np = 0;
    p0 = -1;
    p1 = -1;
    d0 = '0;
    d1 = '0;
    ready_ok = 1'b1;
    seq = 8'h0F;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) seq = 8'hF0;
      bus.in_valid = i < 16;
      bus.in_data = seq[i % 8];
      #1;
      if (i < 16 && !bus.in_ready) ready_ok = 1'b0;
      if (bus.out_valid) begin
        if (np == 0) begin p0 = i; d0 = bus.out_data; end
        else begin p1 = i; d1 = bus.out_data; end
        np++;
      end
      step();
    end
    check("stream_pulses", np, 2);
    check("stream_first_at", p0, 8);
    check("stream_spacing", p1 - p0, 8);
    check("stream_data0", d0, 8'h0F);
    check("stream_data1", d1, 8'hF0);
    check("stream_in_ready", ready_ok, 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    step();
    check("midrst_after_valid", bus.out_valid, 0);
    send_word(8'hAA, 0);
    check("midrst_word_valid", bus.out_valid, 1);
    check("midrst_word_data", bus.out_data, 8'hAA);
    step();
    send_word(8'h4D, 1);
    check("gap_valid", bus.out_valid, 1);
    check("gap_data", bus.out_data, 8'h4D);
    step();
    check("gap_drained", bus.out_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
